alu_cmd_driver: RTL and testbench

ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

---
 rtl/alu_cmd_driver.sv | 112 +++++++++++
 tb/tb_alu_cmd_driver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: takes one command byte, drives operands to a combinational
// ALU, waits WAIT_CYCLES edges for the result to settle, then presents
// {op select, result} as a response held until the consumer takes it.
module alu_cmd_driver #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [1:0] alu_sel,
    input  logic [5:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] op_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The counter is loaded with WAIT_CYCLES-1 so the capture lands exactly
    // WAIT_CYCLES edges after the accept edge.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       accept;
    logic       capture;
    logic       done;

    // Next-state decode and the single-cycle event strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // cmd_ready is gated by rst so it reads 0 for the whole reset pulse
    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Wait counter: loaded on accept, counts down to zero while waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 cnt <= 4'd0;
        else if (accept)                         cnt <= CNT_LOAD;
        else if (state == ST_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    // Operand registers hold from one accept to the next, including in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= 3'd0;
            alu_b   <= 3'd0;
            alu_sel <= 2'd0;
        end else if (accept) begin
            alu_a   <= cmd_data[2:0];
            alu_b   <= cmd_data[5:3];
            alu_sel <= cmd_data[7:6];
        end
    end

    // Response byte keeps its last captured value outside RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rsp_data <= 8'd0;
        else if (capture) rsp_data <= {alu_sel, alu_result};
    end

    // Completed-response counter, wraps naturally at 8 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       op_count <= 8'd0;
        else if (done) op_count <= op_count + 8'd1;
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: a WAIT_CYCLES=2 instance with an ALU
// model for the main scenarios, plus WAIT_CYCLES=1 and 15 instances whose
// ALU result is driven directly by the bench for the latency sweep.
module tb_alu_cmd_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // main instance, WAIT_CYCLES=2
    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [7:0] cmd_data, rsp_data, op_count;
    logic [2:0] alu_a, alu_b;
    logic [1:0] alu_sel;
    logic [5:0] alu_result;

    // WAIT_CYCLES=1 instance
    logic       cv1, cr1, rv1, rr1, bz1;
    logic [7:0] cd1, rd1, oc1;
    logic [2:0] a1, b1;
    logic [1:0] s1;
    logic [5:0] res1;

    // WAIT_CYCLES=15 instance
    logic       cv15, cr15, rv15, rr15, bz15;
    logic [7:0] cd15, rd15, oc15;
    logic [2:0] a15, b15;
    logic [1:0] s15;
    logic [5:0] res15;

    int tests = 0;
    int fails = 0;

    // ALU model: 00 add, 01 sub, 10 and, 11 a*b+33
    function automatic logic [5:0] alu_model(input logic [2:0] a, input logic [2:0] b,
                                             input logic [1:0] sel);
        case (sel)
            2'b00:   return 6'(a) + 6'(b);
            2'b01:   return 6'(a) - 6'(b);
            2'b10:   return 6'(a & b);
            default: return 6'(a) * 6'(b) + 6'd33;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_sel);

    alu_cmd_driver #(.WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .op_count(op_count), .busy(busy)
    );

    alu_cmd_driver #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cv1), .cmd_data(cd1),
        .cmd_ready(cr1), .alu_a(a1), .alu_b(b1), .alu_sel(s1),
        .alu_result(res1), .rsp_valid(rv1), .rsp_ready(rr1),
        .rsp_data(rd1), .op_count(oc1), .busy(bz1)
    );

    alu_cmd_driver #(.WAIT_CYCLES(15)) u_dut15 (
        .clk(clk), .rst(rst), .cmd_valid(cv15), .cmd_data(cd15),
        .cmd_ready(cr15), .alu_a(a15), .alu_b(b15), .alu_sel(s15),
        .alu_result(res15), .rsp_valid(rv15), .rsp_ready(rr15),
        .rsp_data(rd15), .op_count(oc15), .busy(bz15)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, last, gap_err, seen_rsp;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_data = 8'h00; rsp_ready = 1'b0;
        cv1 = 1'b0; cd1 = 8'h00; rr1 = 1'b0; res1 = 6'h05;
        cv15 = 1'b0; cd15 = 8'h00; rr15 = 1'b0; res15 = 6'h11;

        // reset state
        tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_outputs", {rsp_valid, busy, op_count, rsp_data, alu_a, alu_b, alu_sel}, 0);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("post_rst_ready", cmd_ready, 1);

        // basic op: 0x1D -> A=5 B=3 sel=00 -> 8
        cmd_valid = 1'b1; cmd_data = 8'h1D; rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("basic_operands", {alu_a, alu_b, alu_sel}, {3'd5, 3'd3, 2'd0});
        chk("basic_busy_ready", {busy, cmd_ready, rsp_valid}, 3'b100);
        tick();
        chk("basic_no_rsp_n1", rsp_valid, 0);
        tick();
        chk("basic_rsp", {rsp_valid, rsp_data}, {1'b1, 8'h08});
        tick();
        chk("basic_done", {rsp_valid, op_count, rsp_data, alu_a}, {1'b0, 8'd1, 8'h08, 3'd5});

        // backpressure: 0x4A -> A=2 B=1 sel=01 -> 1 -> 0x41
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_data = 8'h4A;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {rsp_valid, rsp_data, cmd_ready}, {1'b1, 8'h41, 1'b0});
            if (i == 3) begin cmd_valid = 1'b1; cmd_data = 8'hFF; end
            else        cmd_valid = 1'b0;
            tick();
        end
        cmd_valid = 1'b0;
        chk("bp_ignored_cmd", {alu_a, alu_b, alu_sel, op_count}, {3'd2, 3'd1, 2'd1, 8'd1});
        rsp_ready = 1'b1;
        tick();
        chk("bp_release", {rsp_valid, op_count}, {1'b0, 8'd2});

        // sel passthrough: 0xC0 -> 0*0+33 = 0x21 -> 0xE1
        cmd_valid = 1'b1; cmd_data = 8'hC0;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        chk("sel11_rsp", {rsp_valid, rsp_data}, {1'b1, 8'hE1});
        tick();
        chk("sel11_count", op_count, 3);

        // async reset while in WAIT: 0x9F -> A=7 B=3 sel=10 -> 3 -> 0x83
        cmd_valid = 1'b1; cmd_data = 8'h9F;
        tick();
        cmd_valid = 1'b0;
        chk("ar_in_wait", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_outputs", {rsp_valid, busy, cmd_ready, op_count, rsp_data, alu_a, alu_b, alu_sel}, 0);
        @(negedge clk) rst = 1'b0;
        seen_rsp = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid) seen_rsp++;
        end
        chk("ar_no_stale_rsp", seen_rsp, 0);
        cmd_valid = 1'b1; cmd_data = 8'h9F;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        chk("ar_next_rsp", {rsp_valid, rsp_data}, {1'b1, 8'h83});
        tick();
        chk("ar_next_count", op_count, 1);

        // wrap: fresh reset, then 256 back-to-back ops
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        #1;
        cmd_valid = 1'b1; cmd_data = 8'h1D; rsp_ready = 1'b1;
        acc = 0; last = -1; gap_err = 0;
        for (int c = 0; c < 1300 && acc < 256; c++) begin
            if (cmd_ready) begin
                if (last >= 0 && c - last != 4) gap_err++;
                last = c;
                acc++;
            end
            tick();
            if (acc == 256) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        chk("wrap_accepts", acc, 256);
        chk("wrap_spacing_errs", gap_err, 0);
        chk("wrap_count", {op_count, busy}, {8'd0, 1'b0});

        // latency WAIT_CYCLES=1: result changes right after accept
        cv1 = 1'b1; cd1 = 8'h40;
        tick();
        cv1 = 1'b0;
        chk("w1_no_rsp_at_accept", rv1, 0);
        res1 = 6'h2A;
        tick();
        chk("w1_capture", {rv1, rd1}, {1'b1, 8'h6A});
        rr1 = 1'b1;
        tick();
        chk("w1_done", {rv1, oc1, bz1}, {1'b0, 8'd1, 1'b0});

        // latency WAIT_CYCLES=15: result changes after edge N+14
        cv15 = 1'b1; cd15 = 8'h80;
        tick();
        cv15 = 1'b0;
        repeat (14) tick();
        chk("w15_no_rsp_n14", rv15, 0);
        res15 = 6'h2C;
        tick();
        chk("w15_capture", {rv15, rd15}, {1'b1, 8'hAC});
        rr15 = 1'b1;
        tick();
        chk("w15_done", {rv15, oc15, bz15, cr15}, {1'b0, 8'd1, 1'b0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
